// File: rtl/sobel_window3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sobel_window3                                                |
// | Description : 3x3 sliding-window generator for a raster pixel stream.      |
// |               Two line buffers plus a two-column shift register build the  |
// |               window. Only interior centres are emitted, with their        |
// |               centre coordinates and an end-of-frame flag.                 |
// | Option      : SOBEL_WIN_SOF_ERR_EN - enables the sticky err flag that       |
// |               reports a start-of-frame arriving mid-frame.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sobel_window3 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [7:0]  in_pixel,
  output logic [7:0]  p0,
  output logic [7:0]  p1,
  output logic [7:0]  p2,
  output logic [7:0]  p3,
  output logic [7:0]  p4,
  output logic [7:0]  p5,
  output logic [7:0]  p6,
  output logic [7:0]  p7,
  output logic [7:0]  p8,
  output logic        out_valid,
  output logic [10:0] out_row,
  output logic [10:0] out_col,
  output logic        out_last,
  output logic        err
);

  // Line-buffer address width; the column counter is sliced down to this.
  localparam int          c_AW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [10:0] c_COL_MAX = 11'(IMG_W - 1);
  localparam logic [10:0] c_ROW_MAX = 11'(IMG_H - 1);

  // Position of the next pixel expected on the stream.
  logic [10:0] col_q;
  logic [10:0] col_d;
  logic [10:0] row_q;
  logic [10:0] row_d;

  // Position actually assigned to the pixel on the input this cycle.
  logic [10:0]    w_pos_col;
  logic [10:0]    w_pos_row;
  logic [c_AW-1:0] w_addr;

  // lb_top_q holds the row two above the incoming pixel, lb_mid_q the row
  // directly above it. Neither memory is reset.
  logic [7:0] lb_top_q [IMG_W];
  logic [7:0] lb_mid_q [IMG_W];
  logic [7:0] w_top;
  logic [7:0] w_mid;

  // The two most recent window columns; index 0 = top, 1 = middle, 2 = bottom.
  // col_a_q is the left column, col_b_q the centre column; the right column
  // is formed on the fly from the line buffers and the incoming pixel.
  logic [2:0][7:0] col_a_q;
  logic [2:0][7:0] col_b_q;

  logic w_emit;
  logic w_last;

  // Resolve pixel position, read line buffers, compute counter advance and emit.
  always_comb begin
    w_pos_col = in_sof ? 11'd0 : col_q;
    w_pos_row = in_sof ? 11'd0 : row_q;
    w_addr    = w_pos_col[c_AW-1:0];
    w_top     = lb_top_q[w_addr];
    w_mid     = lb_mid_q[w_addr];
    col_d     = col_q;
    row_d     = row_q;
    if (in_valid) begin
      if (w_pos_col == c_COL_MAX) begin
        col_d = 11'd0;
        row_d = (w_pos_row == c_ROW_MAX) ? 11'd0 : (w_pos_row + 11'd1);
      end else begin
        col_d = w_pos_col + 11'd1;
        row_d = w_pos_row;
      end
    end
    // A pixel at (r+1,c+1) with r,c >= 1 completes the window centred at (r,c).
    // The left and centre columns were captured earlier in the same row, so an
    // aborted frame can never leak into a window of the new one.
    w_emit = in_valid && (w_pos_row >= 11'd2) && (w_pos_col >= 11'd2);
    w_last = w_emit && (w_pos_row == c_ROW_MAX) && (w_pos_col == c_COL_MAX);
  end

  // Line-buffer update: the middle row ages into the top row as the new pixel lands.
  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      lb_top_q[w_addr] <= w_mid;
      lb_mid_q[w_addr] <= in_pixel;
    end
  end

  // Counters, column shift register and registered window outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= 11'd0;
      row_q     <= 11'd0;
      col_a_q   <= '0;
      col_b_q   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= 11'd0;
      out_col   <= 11'd0;
      p0        <= 8'd0;
      p1        <= 8'd0;
      p2        <= 8'd0;
      p3        <= 8'd0;
      p4        <= 8'd0;
      p5        <= 8'd0;
      p6        <= 8'd0;
      p7        <= 8'd0;
      p8        <= 8'd0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      out_valid <= w_emit;
      out_last  <= w_last;
      if (in_valid) begin
        col_a_q <= col_b_q;
        col_b_q <= {in_pixel, w_mid, w_top};
      end
      if (w_emit) begin
        p0      <= col_a_q[0];
        p3      <= col_a_q[1];
        p6      <= col_a_q[2];
        p1      <= col_b_q[0];
        p4      <= col_b_q[1];
        p7      <= col_b_q[2];
        p2      <= w_top;
        p5      <= w_mid;
        p8      <= in_pixel;
        out_row <= w_pos_row - 11'd1;
        out_col <= w_pos_col - 11'd1;
      end
    end
  end

`ifdef SOBEL_WIN_SOF_ERR_EN
  logic err_q;

  // Sticky flag: a start-of-frame while the stream is not at (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (in_valid && in_sof && ((col_q != 11'd0) || (row_q != 11'd0))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sobel_window3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sobel_window3                                             |
// | Description : Scoreboard bench for sobel_window3 on a 4x4 image with        |
// |               pixel = 16*row + col. Expected windows come from a           |
// |               hand-computed table; a monitor pops and compares them.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sobel_window3;

`ifdef SOBEL_WIN_SOF_ERR_EN
  localparam bit c_ERR_EN = 1'b1;
`else
  localparam bit c_ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_sof;
  logic [7:0]  in_pixel;
  logic [7:0]  p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic        out_valid;
  logic [10:0] out_row;
  logic [10:0] out_col;
  logic        out_last;
  logic        err;

  sobel_window3 #(.IMG_W(4), .IMG_H(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_pixel (in_pixel),
    .p0       (p0),
    .p1       (p1),
    .p2       (p2),
    .p3       (p3),
    .p4       (p4),
    .p5       (p5),
    .p6       (p6),
    .p7       (p7),
    .p8       (p8),
    .out_valid(out_valid),
    .out_row  (out_row),
    .out_col  (out_col),
    .out_last (out_last),
    .err      (err)
  );

  typedef struct {
    int          row;
    int          col;
    logic [71:0] pix;
    bit          last;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Hand-computed windows {p8..p0} for centres (1,1),(1,2),(2,1),(2,2).
  logic [71:0] win_tab [4] = '{
    72'h22_21_20_12_11_10_02_01_00,
    72'h23_22_21_13_12_11_03_02_01,
    72'h32_31_30_22_21_20_12_11_10,
    72'h33_32_31_23_22_21_13_12_11
  };

  logic [71:0] act_pix;
  assign act_pix = {p8, p7, p6, p5, p4, p3, p2, p1, p0};

  logic [71:0] last_pix;
  int          last_row;
  int          last_col;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every presented window, and check outputs hold otherwise.
  always @(negedge clk) begin
    if (rst) begin
      last_pix = '0;
      last_row = 0;
      last_col = 0;
    end else if (out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window actual row=%0d col=%0d required none",
                 out_row, out_col);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (act_pix !== e.pix || int'(out_row) != e.row || int'(out_col) != e.col ||
            out_last !== e.last) begin
          errors++;
          $display("FAIL window_data actual r=%0d c=%0d last=%0b pix=%h required r=%0d c=%0d last=%0b pix=%h",
                   out_row, out_col, out_last, act_pix, e.row, e.col, e.last, e.pix);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL window_latency r=%0d c=%0d actual cycle=%0d required cycle=%0d",
                   e.row, e.col, cyc, e.cyc);
        end
        last_pix = e.pix;
        last_row = e.row;
        last_col = e.col;
      end
    end else begin
      checks++;
      if (act_pix !== last_pix || int'(out_row) != last_row || int'(out_col) != last_col ||
          out_last !== 1'b0) begin
        errors++;
        $display("FAIL output_hold actual r=%0d c=%0d last=%0b pix=%h required r=%0d c=%0d last=0 pix=%h",
                 out_row, out_col, out_last, act_pix, last_row, last_col, last_pix);
      end
    end
  end

  // Drive one accepted pixel; optionally predict the window it completes.
  task automatic send(input logic [7:0] pix, input bit sof, input int r, input int c,
                      input bit track);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = pix;
    if (track && r >= 2 && c >= 2) begin
      exp_t e;
      e.row  = r - 1;
      e.col  = c - 1;
      e.pix  = win_tab[(r - 2) * 2 + (c - 2)];
      e.last = (r == 3 && c == 3);
      e.cyc  = cyc + 1;
      q.push_back(e);
    end
  endtask

  // One idle cycle; sof may be raised without valid to show it is ignored.
  task automatic gap(input bit sof);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = sof;
    in_pixel = 8'hEE;
  endtask

  task automatic frame(input bit sof, input bit toggle);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        send(8'(16 * r + c), sof && r == 0 && c == 0, r, c, 1'b1);
        if (toggle) gap(1'b1);
      end
    end
  endtask

  task automatic check_err(input logic want, input string name);
    @(negedge clk);
    checks++;
    if (err !== want) begin
      errors++;
      $display("FAIL %s actual err=%0b required err=%0b", name, err, want);
    end
  endtask

  task automatic check_zero(input string name);
    @(negedge clk);
    checks++;
    if (act_pix !== '0 || out_row !== 11'd0 || out_col !== 11'd0 || out_valid !== 1'b0 ||
        out_last !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s actual v=%0b last=%0b r=%0d c=%0d err=%0b pix=%h required all zero",
               name, out_valid, out_last, out_row, out_col, err, act_pix);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset_state");

    // Continuous frame with sof on the first pixel.
    frame(1'b1, 1'b0);
    repeat (3) gap(1'b0);

    // Same frame with in_valid toggling; sof pulses without valid in the gaps.
    frame(1'b1, 1'b1);
    repeat (3) gap(1'b0);

    // Two back-to-back frames, the second without sof.
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    gap(1'b0);
    check_err(1'b0, "err_clean_frames");

    // Frame aborted by sof at pixel (1,2), then a full frame.
    for (int i = 0; i < 6; i++) begin
      send(8'hA0 + 8'(i), i == 0, i / 4, i % 4, 1'b0);
    end
    frame(1'b1, 1'b0);
    gap(1'b0);
    check_err(c_ERR_EN, "err_after_abort");

    // Reset pulsed while pixel (2,1) is on the input, then a frame without sof.
    for (int i = 0; i < 9; i++) begin
      send(8'hC0 + 8'(i), i == 0, i / 4, i % 4, 1'b0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_pixel = 8'h55;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check_zero("reset_midframe");
    frame(1'b0, 1'b0);
    gap(1'b0);

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_window actual none required r=%0d c=%0d", e.row, e.col);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
